// File: rtl/sr_tx.sv
// rtl/sr_tx.sv - serial MSB-first transmitter driving the i4003 cp/data/e interface
// Optional feature: define SR_TX_BLANK_EN to hold sr_e low while a word is shifting.
module sr_tx #(
    parameter int WIDTH = 10,
    parameter int DIV   = 2
) (
    input  logic             cp1,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sr_cp,
    output logic             sr_data,
    output logic             sr_e,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;

    // State, divider, bit counter and shift register with synchronous reset
    always_ff @(posedge cp1) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 5'd0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state: accept in IDLE, DIV cycles per phase, shift at end of each HI
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = LO;
                    div_d   = 8'd0;
                    bit_d   = 5'd0;
                    shreg_d = tx_data;
                end
            end
            LO: begin
                if (div_q == DIV_LAST) begin
                    state_d = HI;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HI: begin
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        shreg_d = shreg_q << 1;
                        bit_d   = bit_q + 5'd1;
                        state_d = LO;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                bit_d   = 5'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only, so they change exactly on cp1 edges
    always_comb begin
        tx_ready = (state_q == IDLE);
        busy     = (state_q == LO) || (state_q == HI);
        done     = (state_q == DONE);
        sr_cp    = (state_q == HI);
        sr_data  = busy & shreg_q[WIDTH-1];
`ifdef SR_TX_BLANK_EN
        sr_e     = ~busy;
`else
        sr_e     = 1'b1;
`endif
    end

endmodule

// File: tb/tb_sr_tx.sv
// tb/tb_sr_tx.sv - self-checking bench for sr_tx with a timing-rule model and i4003 receivers
module tb_sr_tx;

    localparam int W0 = 10;
    localparam int D0 = 2;
    localparam int W1 = 4;
    localparam int D1 = 1;

    logic          cp1 = 1'b0;
    logic          reset;
    logic [W0-1:0] data0;
    logic          valid0;
    logic [W1-1:0] data1;
    logic          valid1;
    logic ready0, cp0, sd0, e0, busy0, done0;
    logic ready1, cpb, sd1, e1, busy1, done1;

    int checks = 0;
    int failures = 0;

    sr_tx #(.WIDTH(W0), .DIV(D0)) dut0 (
        .cp1(cp1), .reset(reset), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(ready0), .sr_cp(cp0), .sr_data(sd0), .sr_e(e0),
        .busy(busy0), .done(done0)
    );

    sr_tx #(.WIDTH(W1), .DIV(D1)) dut1 (
        .cp1(cp1), .reset(reset), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(ready1), .sr_cp(cpb), .sr_data(sd1), .sr_e(e1),
        .busy(busy1), .done(done1)
    );

    always #5 cp1 = ~cp1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {sr_cp, sr_data, sr_e, busy, done, tx_ready} n cycles after an accept
    function automatic logic [5:0] exp_out(input bit act, input int n, input logic [31:0] w,
                                           input int wd, input int dv);
        int  k;
        bit  hi;
        bit  ev;
        if (!act || n > 2 * wd * dv + 1) return 6'b001001;
        if (n == 2 * wd * dv + 1) return 6'b001010;
        k  = (n - 1) / (2 * dv);
        hi = ((n - 1) % (2 * dv)) >= dv;
`ifdef SR_TX_BLANK_EN
        ev = 1'b0;
`else
        ev = 1'b1;
`endif
        return {hi, w[wd-1-k], ev, 1'b1, 1'b0, 1'b0};
    endfunction

    // Model state: whether a word is in flight and how many edges since its accept
    bit          act0 = 0, act1 = 0;
    int          n0 = 0, n1 = 0;
    logic [31:0] w0 = 0, w1 = 0;
    int          cyc = 0;
    int          dacc0[$];
    int          dacc1[$];
    bit          chk_en = 0;
    int          dones0 = 0, dones1 = 0;

    // Model advance plus log of DUT-observed accepts, both on the active edge
    always @(posedge cp1) begin
        int c_now;
        c_now = cyc + 1;
        cyc <= c_now;
        if (reset) begin
            act0 <= 0;
            act1 <= 0;
        end else begin
            if ((!act0 || n0 >= 2 * W0 * D0 + 2) && valid0 === 1'b1) begin
                act0 <= 1; n0 <= 1; w0 <= 32'(data0);
            end else if (act0) n0 <= n0 + 1;
            if ((!act1 || n1 >= 2 * W1 * D1 + 2) && valid1 === 1'b1) begin
                act1 <= 1; n1 <= 1; w1 <= 32'(data1);
            end else if (act1) n1 <= n1 + 1;
            if (ready0 === 1'b1 && valid0 === 1'b1) dacc0.push_back(c_now);
            if (ready1 === 1'b1 && valid1 === 1'b1) dacc1.push_back(c_now);
        end
    end

    // Per-cycle comparison of both DUTs against the model
    always @(negedge cp1) begin
        if (chk_en) begin
            check("dut0_cycle", 32'({cp0, sd0, e0, busy0, done0, ready0}),
                  32'(exp_out(act0, n0, w0, W0, D0)));
            check("dut1_cycle", 32'({cpb, sd1, e1, busy1, done1, ready1}),
                  32'(exp_out(act1, n1, w1, W1, D1)));
            if (done0) dones0++;
            if (done1) dones1++;
        end
    end

    // i4003-style receivers: shift in sr_data on each rising sr_cp
    logic [W0-1:0] p0 = '0;
    logic [W1-1:0] p1 = '0;
    int rises0 = 0, rises1 = 0;
    always @(posedge cp0) begin
        p0     <= {p0[W0-2:0], sd0};
        rises0 <= rises0 + 1;
    end
    always @(posedge cpb) begin
        p1     <= {p1[W1-2:0], sd1};
        rises1 <= rises1 + 1;
    end

    task automatic wait_done(input bit which, output int label);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge cp1);
            if ((which ? done1 : done0) === 1'b1) break;
        end
        check(which ? "dut1_done_timeout" : "dut0_done_timeout", 32'(i < 200), 32'd1);
        label = cyc + 1;
    endtask

    initial begin
        int lbl, lbl2, r0, r1, nd, na;
        bit ready_seen;
        reset = 1; valid0 = 0; valid1 = 0; data0 = '0; data1 = '0;
        repeat (3) @(negedge cp1);
        check("reset_dut0", 32'({cp0, sd0, e0, busy0, done0, ready0}), 32'h09);
        check("reset_dut1", 32'({cpb, sd1, e1, busy1, done1, ready1}), 32'h09);
        chk_en = 1;
        reset  = 0;
        @(negedge cp1);

        // Basic word on both instances, including the DIV=1 minimum divider
        r0 = rises0; r1 = rises1;
        data0 = 10'h2A5; valid0 = 1;
        data1 = 4'b1001; valid1 = 1;
        @(negedge cp1);
        valid0 = 0; valid1 = 0;
        wait_done(1'b1, lbl);
        check("min_div_done_time", 32'(lbl - dacc1[$]), 32'd9);
        check("min_div_p_out", 32'(p1), 32'h9);
        check("min_div_rises", 32'(rises1 - r1), 32'd4);
        wait_done(1'b0, lbl);
        check("basic_done_time", 32'(lbl - dacc0[$]), 32'd41);
        check("basic_p_out", 32'(p0), 32'h2A5);
        check("basic_rises", 32'(rises0 - r0), 32'd10);

        // Back-to-back words with tx_valid held high
        @(negedge cp1);
        r0 = rises0; nd = dones0; na = dacc0.size();
        data0 = 10'h3FF; valid0 = 1;
        @(negedge cp1);
        data0 = 10'h001;
        wait_done(1'b0, lbl);
        wait_done(1'b0, lbl2);
        valid0 = 0;
        check("b2b_accepts", 32'(dacc0.size() - na), 32'd2);
        check("b2b_second_accept", 32'(dacc0[$] - dacc0[$-1]), 32'd42);
        check("b2b_done_spacing", 32'(lbl2 - lbl), 32'd42);
        check("b2b_rises", 32'(rises0 - r0), 32'd20);
        check("b2b_p_out", 32'(p0), 32'h001);
        @(negedge cp1);
        check("b2b_dones", 32'(dones0 - nd), 32'd2);

        // Input changes while busy must be ignored
        @(negedge cp1);
        na = dacc0.size(); ready_seen = 0;
        data0 = 10'h2D1; valid0 = 1;
        @(negedge cp1);
        data0 = 10'h000;
        for (int i = 0; i < 30; i++) begin
            valid0 = ~valid0;
            @(negedge cp1);
            if (ready0 !== 1'b0) ready_seen = 1;
        end
        valid0 = 0;
        wait_done(1'b0, lbl);
        check("stable_p_out", 32'(p0), 32'h2D1);
        check("stable_accepts", 32'(dacc0.size() - na), 32'd1);
        check("stable_ready_low", 32'(ready_seen), 32'd0);

        // Reset during bit 4 aborts the word without a done pulse
        @(negedge cp1);
        r0 = rises0;
        data0 = 10'h155; valid0 = 1;
        @(negedge cp1);
        valid0 = 0;
        for (int i = 0; i < 100 && rises0 - r0 < 4; i++) @(negedge cp1);
        check("reset_reach_bit4", 32'(rises0 - r0), 32'd4);
        nd = dones0;
        reset = 1;
        @(negedge cp1);
        reset = 0;
        check("midword_reset_out", 32'({cp0, sd0, e0, busy0, done0, ready0}), 32'h09);
        repeat (50) @(negedge cp1);
        check("midword_no_done", 32'(dones0 - nd), 32'd0);
        data0 = 10'h0F0; valid0 = 1;
        @(negedge cp1);
        valid0 = 0;
        wait_done(1'b0, lbl);
        check("after_reset_p_out", 32'(p0), 32'h0F0);
        repeat (3) @(negedge cp1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
